// File: rtl/pair_sum_pkg.sv
// Shared defaults and helpers for the pair-sum datapath.
package pair_sum_pkg;

  localparam int W_DEFAULT       = 8;
  localparam int DEPTH_A_DEFAULT = 8;
  localparam int SUM_W_DEFAULT   = W_DEFAULT + 1;

  // $clog2 that never returns zero, so a one-entry buffer still gets a
  // legal one-bit pointer/address.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pair_sum_datapath_wrap_ptr.sv
// Wrapping pointer: synchronous reset, increment enable, wraps to zero
// after DEPTH-1.
module wrap_ptr
  import pair_sum_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  // Pointer register; explicit wrap keeps non-power-of-two depths correct.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pair_sum_datapath.sv
// Pair-sum datapath: captures words into buffer A, accumulates consecutive
// pairs from A into a registered sum, and stores each sum into buffer B.
// Driven directly by the controller's wea/inca/web/incb strobes.
module pair_sum_datapath
  import pair_sum_pkg::*;
#(
  parameter  int W       = W_DEFAULT,
  parameter  int DEPTH_A = DEPTH_A_DEFAULT,
  localparam int DEPTH_B = DEPTH_A / 2,
  localparam int AW      = clog2_min1(DEPTH_A),
  localparam int BW      = clog2_min1(DEPTH_B)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wea,
  input  logic          inca,
  input  logic          web,
  input  logic          incb,
  input  logic [W-1:0]  din,
  input  logic [BW-1:0] raddr_b,
  output logic [W:0]    dout_b,
  output logic [W:0]    acc_out,
  output logic          done,
  output logic          err
);

  localparam int SUM_W = W + 1;
  // b_cnt must be able to hold DEPTH_B itself.
  localparam int CW = clog2_min1(DEPTH_B + 1);
  localparam logic [CW-1:0] B_LAST = CW'(DEPTH_B - 1);
  localparam logic [CW-1:0] B_FULL = CW'(DEPTH_B);

  logic [W-1:0]     mem_a [DEPTH_A];
  logic [SUM_W-1:0] mem_b [DEPTH_B];

  logic [AW-1:0]    ptr_a;
  logic [BW-1:0]    ptr_b;
  logic [SUM_W-1:0] acc;
  logic             phase;
  logic [CW-1:0]    b_cnt;

  logic [W-1:0]     rd_a;
  logic             acc_cycle;
  logic             b_error;
  logic             b_write;

  wrap_ptr #(.WIDTH(AW), .DEPTH(DEPTH_A)) u_ptr_a (
    .clk   (clk),
    .reset (reset),
    .inc   (inca),
    .ptr   (ptr_a)
  );

  wrap_ptr #(.WIDTH(BW), .DEPTH(DEPTH_B)) u_ptr_b (
    .clk   (clk),
    .reset (reset),
    .inc   (incb),
    .ptr   (ptr_b)
  );

  // Strobe decode: buffer A read, accumulate qualification, B write gating.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    rd_a      = mem_a[ptr_a];
    acc_cycle = inca & ~wea;
    // A B write is illegal while A is being written or with half a pair in acc.
    b_error   = web & (wea | phase);
    b_write   = web & ~b_error;
  end

  // Buffer A storage: written at the current pointer, never cleared.
  // NOTE: this array has no reset on purpose; its contents are always
  // rewritten before they are read, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wea) begin
      mem_a[ptr_a] <= din;
    end
  end

  // Buffer B storage: fully cleared by reset so readers see zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_B; i++) begin
        mem_b[i] <= '0;
      end
    end else if (b_write) begin
      mem_b[ptr_b] <= acc;
    end
  end

  // Accumulator: load first word of a pair, add the second at full width.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      phase <= 1'b0;
    end else if (acc_cycle) begin
      phase <= ~phase;
      acc   <= phase ? acc + {1'b0, rd_a} : {1'b0, rd_a};
    end
  end

  // Status: count accepted B writes (saturating), sticky done and err.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_cnt <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (b_write && b_cnt != B_FULL) begin
        b_cnt <= b_cnt + CW'(1);
      end
      if (b_write && b_cnt == B_LAST) begin
        done <= 1'b1;
      end
      if (b_error) begin
        err <= 1'b1;
      end
    end
  end

  assign dout_b  = mem_b[raddr_b];
  assign acc_out = acc;

endmodule

// File: tb/tb_pair_sum_datapath.sv
// Self-checking bench for pair_sum_datapath: controller sequences with
// fixed and random data, checked against pair sums computed in the bench.
`timescale 1ns/1ps
module tb_pair_sum_datapath;

  typedef logic [7:0] data_t [8];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wea = 1'b0;
  logic       inca = 1'b0;
  logic       web = 1'b0;
  logic       incb = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] raddr_b = '0;
  logic [8:0] dout_b;
  logic [8:0] acc_out;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  pair_sum_datapath dut (
    .clk     (clk),
    .reset   (reset),
    .wea     (wea),
    .inca    (inca),
    .web     (web),
    .incb    (incb),
    .din     (din),
    .raddr_b (raddr_b),
    .dout_b  (dout_b),
    .acc_out (acc_out),
    .done    (done),
    .err     (err)
  );

  always #10 clk = ~clk;

  // Reference: a pair sum is the plain 9-bit sum of two consecutive words.
  function automatic logic [8:0] pair(input data_t d, input int k);
    return 9'(d[2*k]) + 9'(d[2*k+1]);
  endfunction

  // One clock cycle with the given strobes; returns 1 ns after the edge.
  task automatic step(input logic a_we, input logic a_inc, input logic b_we,
                      input logic b_inc, input logic [7:0] d);
    wea  = a_we;
    inca = a_inc;
    web  = b_we;
    incb = b_inc;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic read_b(input int addr, output logic [8:0] v);
    raddr_b = 2'(addr);
    #1;
    v = dout_b;
  endtask

  // Controller cycle c of the standard sequence; first B write at first_web.
  task automatic seq_cycle(input int c, input data_t d, input int first_web);
    logic a_we, a_inc, b_we, b_inc;
    logic [7:0] dd;
    a_we  = (c >= 1 && c <= 8);
    a_inc = (c >= 1 && c <= 16);
    b_we  = (c == first_web || c == 13 || c == 15 || c == 17);
    b_inc = (c == 12 || c == 14 || c == 16 || c == 18);
    dd    = a_we ? d[c-1] : 8'($urandom);
    step(a_we, a_inc, b_we, b_inc, dd);
  endtask

  task automatic test_reset();
    logic [8:0] v;
    do_reset();
    checks++;
    if (acc_out !== 9'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", acc_out); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    for (int k = 0; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== 9'd0) begin errors++; $display("FAIL reset_mem_b[%0d] got %0d want 0", k, v); end
    end
  endtask

  task automatic test_nominal();
    data_t d;
    logic [8:0] v;
    logic [8:0] want [4];
    want = '{9'd3, 9'd7, 9'd11, 9'd15};
    for (int i = 0; i < 8; i++) d[i] = 8'(i + 1);
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      seq_cycle(c, d, 11);
      // Values now reflect the start of cycle c+1.
      checks++;
      if (done !== 1'((c + 1) >= 18)) begin
        errors++; $display("FAIL nominal_done c=%0d got %b want %b", c + 1, done, (c + 1) >= 18);
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL nominal_err c=%0d got %b want 0", c + 1, err); end
      if (c == 9) begin
        checks++;
        if (acc_out !== 9'd1) begin errors++; $display("FAIL nominal_acc_c10 got %0d want 1", acc_out); end
      end
      if (c == 10) begin
        checks++;
        if (acc_out !== 9'd3) begin errors++; $display("FAIL nominal_acc_c11 got %0d want 3", acc_out); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== want[k]) begin errors++; $display("FAIL nominal_mem_b[%0d] got %0d want %0d", k, v, want[k]); end
    end
  endtask

  task automatic test_pair_width();
    data_t d;
    logic [8:0] v;
    for (int i = 0; i < 8; i++) d[i] = 8'hFF;
    do_reset();
    for (int c = 0; c <= 19; c++) seq_cycle(c, d, 11);
    for (int k = 0; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== 9'h1FE) begin errors++; $display("FAIL width_mem_b[%0d] got %0d want 510", k, v); end
    end
  endtask

  task automatic test_random();
    data_t d;
    logic [8:0] v;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c <= 19; c++) seq_cycle(c, d, 11);
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL random_flags it=%0d got done=%b err=%b want done=1 err=0", it, done, err);
      end
      for (int k = 0; k < 4; k++) begin
        read_b(k, v);
        checks++;
        if (v !== pair(d, k)) begin
          errors++; $display("FAIL random_mem_b[%0d] it=%0d got %0d want %0d", k, it, v, pair(d, k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    data_t d;
    logic [8:0] v;
    logic [8:0] want [4];
    want = '{9'd21, 9'd25, 9'd29, 9'd33};
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(1, 255));
    do_reset();
    for (int c = 0; c <= 11; c++) seq_cycle(c, d, 11);
    read_b(0, v);
    checks++;
    if (v !== pair(d, 0)) begin errors++; $display("FAIL midreset_pre_mem_b0 got %0d want %0d", v, pair(d, 0)); end
    // Reset coincides with the c=12 strobes and must win over them.
    reset = 1'b1;
    seq_cycle(12, d, 11);
    reset = 1'b0;
    checks++;
    if (acc_out !== 9'd0) begin errors++; $display("FAIL midreset_acc got %0d want 0", acc_out); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got done=%b err=%b want 0 0", done, err);
    end
    for (int k = 0; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== 9'd0) begin errors++; $display("FAIL midreset_mem_b[%0d] got %0d want 0", k, v); end
    end
    for (int i = 0; i < 8; i++) d[i] = 8'(10 + i);
    for (int c = 0; c <= 19; c++) seq_cycle(c, d, 11);
    for (int k = 0; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== want[k]) begin errors++; $display("FAIL midreset_post_mem_b[%0d] got %0d want %0d", k, v, want[k]); end
    end
  endtask

  task automatic test_half_pair();
    data_t d;
    logic [8:0] v;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(1, 255));
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      seq_cycle(c, d, 10);
      checks++;
      if (err !== 1'((c + 1) >= 11)) begin
        errors++; $display("FAIL halfpair_err c=%0d got %b want %b", c + 1, err, (c + 1) >= 11);
      end
      if (c == 10) begin
        checks++;
        if (acc_out !== pair(d, 0)) begin
          errors++; $display("FAIL halfpair_acc_c11 got %0d want %0d", acc_out, pair(d, 0));
        end
      end
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL halfpair_done got %b want 0", done); end
    read_b(0, v);
    checks++;
    if (v !== 9'd0) begin errors++; $display("FAIL halfpair_mem_b0 got %0d want 0", v); end
    for (int k = 1; k < 4; k++) begin
      read_b(k, v);
      checks++;
      if (v !== pair(d, k)) begin errors++; $display("FAIL halfpair_mem_b[%0d] got %0d want %0d", k, v, pair(d, k)); end
    end
  endtask

  task automatic test_collision();
    logic [8:0] v;
    do_reset();
    // Build acc = 0x33 + 0x44 with phase back at 0 and ptr_a at 2.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h44);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (acc_out !== 9'h077 || err !== 1'b0) begin
      errors++; $display("FAIL collision_setup got acc=%0h err=%b want acc=77 err=0", acc_out, err);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL collision_err got %b want 1", err); end
    read_b(0, v);
    checks++;
    if (v !== 9'd0) begin errors++; $display("FAIL collision_mem_b0 got %0h want 0", v); end
    // Accumulate from A[2] to prove the A write still happened.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (acc_out !== 9'h05A) begin errors++; $display("FAIL collision_mem_a got %0h want 5a", acc_out); end
  endtask

  task automatic test_wrap_done();
    data_t d;
    logic [8:0] v;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(0, 100));
    do_reset();
    for (int c = 0; c <= 19; c++) seq_cycle(c, d, 11);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL wrap_done_pre got %b want 1", done); end
    // New pair 200+201 into A[0..1], then a fifth write/advance.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd201);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    read_b(0, v);
    checks++;
    if (v !== 9'd401) begin errors++; $display("FAIL wrap_mem_b0 got %0d want 401", v); end
    read_b(1, v);
    checks++;
    if (v !== pair(d, 1)) begin errors++; $display("FAIL wrap_mem_b1 got %0d want %0d", v, pair(d, 1)); end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL wrap_flags got done=%b err=%b want 1 0", done, err);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pair_width();
    test_random();
    test_reset_mid();
    test_half_pair();
    test_collision();
    test_wrap_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
